// File: rtl/alu_mult_seq_pkg.sv
// alu_mult_seq_pkg
//   Shared constants and types for the multi-cycle MULT/MULTU sequencer.
//   Holds the CPU word size, the ALU op-code encodings that the shared
//   execute-stage ALU understands, and the sequencer state encoding.
//   No ports (package).
package alu_mult_seq_pkg;

  // CPU word width and ALU op-code field size (op port is ALU_OSIZE+1 bits).
  localparam int CPU_WSIZE = 32;
  localparam int ALU_OSIZE = 3;
  localparam int ALU_OPW   = ALU_OSIZE + 1;

  // ALU op codes used by the sequencer; the ALU itself lives outside.
  localparam logic [ALU_OPW-1:0] ALU_ADD_OP = 4'd0;
  localparam logic [ALU_OPW-1:0] ALU_SUB_OP = 4'd1;
  localparam logic [ALU_OPW-1:0] ALU_NOR_OP = 4'd6;

  // Sequencer states (3-bit encoding).
  typedef enum logic [2:0] {
    MSEQ_IDLE   = 3'd0,
    MSEQ_NEG_A  = 3'd1,
    MSEQ_NEG_B  = 3'd2,
    MSEQ_ITER   = 3'd3,
    MSEQ_FIX_LO = 3'd4,
    MSEQ_FIX_HI = 3'd5,
    MSEQ_DONE   = 3'd6
  } mseq_state_e;

endpackage

// File: rtl/alu_mult_seq_if.sv
// alu_mult_seq_if
//   Bundle between the execute stage and the multiply sequencer.
//   Request side : start, sgn, a, b            (into the sequencer)
//   Result side  : busy, done, hi, lo          (out of the sequencer)
//   ALU sharing  : alu_sel, alu_op, alu_a, alu_b (out), alu_r (in, combinational)
//   Modports: master = execute stage / ALU owner, slave = sequencer.
interface alu_mult_seq_if
  import alu_mult_seq_pkg::*;
#(
  parameter int W = CPU_WSIZE
) ();

  logic               start;
  logic               sgn;
  logic [W-1:0]       a;
  logic [W-1:0]       b;
  logic               busy;
  logic               done;
  logic [W-1:0]       hi;
  logic [W-1:0]       lo;
  logic               alu_sel;
  logic [ALU_OPW-1:0] alu_op;
  logic [W-1:0]       alu_a;
  logic [W-1:0]       alu_b;
  logic [W-1:0]       alu_r;

  modport master (
    output start, sgn, a, b, alu_r,
    input  busy, done, hi, lo, alu_sel, alu_op, alu_a, alu_b
  );

  modport slave (
    input  start, sgn, a, b, alu_r,
    output busy, done, hi, lo, alu_sel, alu_op, alu_a, alu_b
  );

endinterface

// File: rtl/alu_mult_seq.sv
// alu_mult_seq
//   Shift-and-add W x W -> 2W multiplier that borrows the CPU's single ALU,
//   doing one ALU add per cycle. While busy it owns the ALU operand mux via
//   alu_sel and the pipeline stalls on busy.
//
//   Ports:
//     clk  - clock, all state updates on the rising edge
//     rst  - synchronous, active-high reset (aborts any operation)
//     bus  - alu_mult_seq_if.slave: start/sgn/a/b request, busy/done/hi/lo
//            result, alu_sel/alu_op/alu_a/alu_b drive and alu_r return
//
//   Build option: MULT_SIGNED_EN
//     defined   - NEG_A/NEG_B pre-negate negative operands, FIX_LO/FIX_HI
//                 negate the 2W product when signs differ; sgn selects
//                 MULT vs MULTU; latency W+5.
//     undefined - those states do not exist, sgn is ignored, every
//                 operation is MULTU; latency W+1.
module alu_mult_seq
  import alu_mult_seq_pkg::*;
#(
  parameter int W  = CPU_WSIZE,
  parameter int CW = $clog2(W) + 1
) (
  input  logic           clk,
  input  logic           rst,
  alu_mult_seq_if.slave  bus
);

  mseq_state_e        state_r;
  mseq_state_e        next_s;

  logic [W-1:0]       mcand_r;
  logic [W-1:0]       hi_r;
  logic [W-1:0]       lo_r;
  logic [CW-1:0]      count_r;

  logic               carry_s;
  logic               busy_s;
  logic               done_s;
  logic [ALU_OPW-1:0] alu_op_s;
  logic [W-1:0]       alu_a_s;
  logic [W-1:0]       alu_b_s;

`ifdef MULT_SIGNED_EN
  logic               sgn_r;
  logic               neg_r;
  logic               lo_was_zero_r;
`else
  // sgn has no effect in the unsigned-only build.
  logic               unused_sgn_s;
  assign unused_sgn_s = bus.sgn;
`endif

  // The ALU returns only W bits; rebuild the add carry-out from the operand
  // and result sign bits (hi + mcand in ITER).
  assign carry_s = (hi_r[W-1] & mcand_r[W-1]) |
                   ((hi_r[W-1] | mcand_r[W-1]) & ~bus.alu_r[W-1]);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= MSEQ_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      MSEQ_IDLE: begin
        if (bus.start) begin
`ifdef MULT_SIGNED_EN
          next_s = MSEQ_NEG_A;
`else
          next_s = MSEQ_ITER;
`endif
        end else begin
          next_s = MSEQ_IDLE;
        end
      end
`ifdef MULT_SIGNED_EN
      MSEQ_NEG_A:  next_s = MSEQ_NEG_B;
      MSEQ_NEG_B:  next_s = MSEQ_ITER;
`endif
      MSEQ_ITER: begin
        if (count_r == CW'(1'b1)) begin
`ifdef MULT_SIGNED_EN
          next_s = MSEQ_FIX_LO;
`else
          next_s = MSEQ_DONE;
`endif
        end else begin
          next_s = MSEQ_ITER;
        end
      end
`ifdef MULT_SIGNED_EN
      MSEQ_FIX_LO: next_s = MSEQ_FIX_HI;
      MSEQ_FIX_HI: next_s = MSEQ_DONE;
`endif
      MSEQ_DONE:   next_s = MSEQ_IDLE;
      default:     next_s = MSEQ_IDLE;
    endcase
  end

  // Output decode: status flags and the ALU operand/op drive per state.
  always_comb begin
    busy_s   = (state_r != MSEQ_IDLE);
    done_s   = (state_r == MSEQ_DONE);
    alu_op_s = ALU_ADD_OP;
    alu_a_s  = {W{1'b0}};
    alu_b_s  = {W{1'b0}};
    case (state_r)
      MSEQ_ITER: begin
        alu_op_s = ALU_ADD_OP;
        alu_a_s  = hi_r;
        alu_b_s  = mcand_r;
      end
`ifdef MULT_SIGNED_EN
      MSEQ_NEG_A: begin
        alu_op_s = ALU_SUB_OP;
        alu_b_s  = mcand_r;
      end
      MSEQ_NEG_B: begin
        alu_op_s = ALU_SUB_OP;
        alu_b_s  = lo_r;
      end
      MSEQ_FIX_LO: begin
        alu_op_s = ALU_SUB_OP;
        alu_b_s  = lo_r;
      end
      MSEQ_FIX_HI: begin
        // Two's complement of {hi,lo}: the +1 only ripples into hi when lo
        // was zero, otherwise hi is just inverted (NOR with zero).
        if (lo_was_zero_r) begin
          alu_op_s = ALU_SUB_OP;
          alu_b_s  = hi_r;
        end else begin
          alu_op_s = ALU_NOR_OP;
          alu_a_s  = hi_r;
        end
      end
`endif
      default: begin
        alu_op_s = ALU_ADD_OP;
      end
    endcase
  end

  // Datapath registers: operand capture, negation, shift-and-add steps.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_r       <= {W{1'b0}};
      hi_r          <= {W{1'b0}};
      lo_r          <= {W{1'b0}};
      count_r       <= {CW{1'b0}};
`ifdef MULT_SIGNED_EN
      sgn_r         <= 1'b0;
      neg_r         <= 1'b0;
      lo_was_zero_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        MSEQ_IDLE: begin
          if (bus.start) begin
            mcand_r       <= bus.a;
            lo_r          <= bus.b;
            hi_r          <= {W{1'b0}};
            count_r       <= CW'(W);
`ifdef MULT_SIGNED_EN
            sgn_r         <= bus.sgn;
            neg_r         <= bus.sgn & (bus.a[W-1] ^ bus.b[W-1]);
            lo_was_zero_r <= 1'b0;
`endif
          end
        end
`ifdef MULT_SIGNED_EN
        MSEQ_NEG_A: begin
          if (sgn_r && mcand_r[W-1]) begin
            mcand_r <= bus.alu_r;
          end
        end
        MSEQ_NEG_B: begin
          if (sgn_r && lo_r[W-1]) begin
            lo_r <= bus.alu_r;
          end
        end
`endif
        MSEQ_ITER: begin
          // lo doubles as the multiplier shift register; product bits enter
          // from the top as multiplier bits leave from the bottom.
          if (lo_r[0]) begin
            {hi_r, lo_r} <= {carry_s, bus.alu_r, lo_r[W-1:1]};
          end else begin
            {hi_r, lo_r} <= {1'b0, hi_r, lo_r[W-1:1]};
          end
          count_r <= count_r - CW'(1'b1);
        end
`ifdef MULT_SIGNED_EN
        MSEQ_FIX_LO: begin
          if (neg_r) begin
            lo_r          <= bus.alu_r;
            lo_was_zero_r <= (lo_r == {W{1'b0}});
          end
        end
        MSEQ_FIX_HI: begin
          if (neg_r) begin
            hi_r <= bus.alu_r;
          end
        end
`endif
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign bus.busy    = busy_s;
  assign bus.done    = done_s;
  assign bus.hi      = hi_r;
  assign bus.lo      = lo_r;
  assign bus.alu_sel = busy_s;
  assign bus.alu_op  = alu_op_s;
  assign bus.alu_a   = alu_a_s;
  assign bus.alu_b   = alu_b_s;

endmodule

// File: tb/tb_alu_mult_seq.sv
// tb_alu_mult_seq
//   Directed-vector bench for alu_mult_seq. Provides the external ALU as a
//   small combinational model, applies a table of {sgn, a, b, hi, lo}
//   records, then runs hand-written sequences for start-while-busy and
//   reset mid-operation. Latency is counted in cycles after the accepting
//   edge: the first falling edge after it is cycle 1.
//   Signed vectors are added when MULT_SIGNED_EN is defined.
module tb_alu_mult_seq;
  import alu_mult_seq_pkg::*;

  localparam int W = CPU_WSIZE;
`ifdef MULT_SIGNED_EN
  localparam int LAT      = W + 5;
  localparam int ITER_OFS = 2;
`else
  localparam int LAT      = W + 1;
  localparam int ITER_OFS = 0;
`endif

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  alu_mult_seq_if #(.W(W)) bus ();

  alu_mult_seq #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External shared ALU.
  always_comb begin
    case (bus.alu_op)
      ALU_ADD_OP: bus.alu_r = bus.alu_a + bus.alu_b;
      ALU_SUB_OP: bus.alu_r = bus.alu_a - bus.alu_b;
      ALU_NOR_OP: bus.alu_r = ~(bus.alu_a | bus.alu_b);
      default:    bus.alu_r = {W{1'b0}};
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Run one operation; returns latency (0 if done never came), result and
  // the done/busy levels on the cycle after done.
  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [W-1:0] hi, output logic [W-1:0] lo,
                        output logic done_after, output logic busy_after);
    @(negedge clk);
    bus.start = 1'b1; bus.sgn = s; bus.a = a; bus.b = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0; hi = '0; lo = '0; done_after = 1'b1; busy_after = 1'b1;
    for (int k = 1; k <= 200 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k; hi = bus.hi; lo = bus.lo;
      end
    end
    @(negedge clk);
    done_after = bus.done;
    busy_after = bus.busy;
  endtask

  function automatic logic [63:0] model_prod(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] ea, eb;
`ifdef MULT_SIGNED_EN
    ea = s ? {{32{a[W-1]}}, a} : {32'd0, a};
    eb = s ? {{32{b[W-1]}}, b} : {32'd0, b};
`else
    ea = {32'd0, a};
    eb = {32'd0, b};
`endif
    return ea * eb;
  endfunction

  initial begin
    int           lat;
    logic [W-1:0] hi, lo;
    logic         d_after, b_after;
    int           n_done;
    logic [63:0]  p;

    // Hand-computed vectors valid in both builds.
    vecs.push_back('{1'b0, 32'd3,          32'd5,          32'h0000_0000, 32'h0000_000F});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'd2,          32'h0000_0001, 32'hFFFF_FFFE});
    vecs.push_back('{1'b0, 32'h0000_FFFF,  32'h0000_FFFF,  32'h0000_0000, 32'hFFFE_0001});
    vecs.push_back('{1'b0, 32'd7,          32'd0,          32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{1'b0, 32'h8000_0000,  32'd2,          32'h0000_0001, 32'h0000_0000});
`ifdef MULT_SIGNED_EN
    vecs.push_back('{1'b0, 32'hFFFF_FFFD,  32'd5,          32'h0000_0004, 32'hFFFF_FFF1});
    vecs.push_back('{1'b1, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1});
    vecs.push_back('{1'b1, 32'd3,          32'hFFFF_FFFB,  32'hFFFF_FFFF, 32'hFFFF_FFF1});
    vecs.push_back('{1'b1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000});
    vecs.push_back('{1'b1, 32'hFFFF_FFFC,  32'h4000_0000,  32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0001});
    vecs.push_back('{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFA,  32'h0000_0000, 32'h0000_002A});
    vecs.push_back('{1'b1, 32'h7FFF_FFFF,  32'h8000_0000,  32'hC000_0000, 32'h8000_0000});
`else
    // sgn has no effect without the signed option.
    vecs.push_back('{1'b1, 32'hFFFF_FFFD,  32'd5,          32'h0000_0004, 32'hFFFF_FFF1});
`endif
    // A few pseudo-random operands checked against a 64-bit product.
    for (int i = 0; i < 4; i++) begin
      vec_t v;
      v.sgn = 1'(i % 2);
      v.a   = 32'($urandom);
      v.b   = 32'($urandom);
      p     = model_prod(v.sgn, v.a, v.b);
      v.hi  = p[63:32];
      v.lo  = p[31:0];
      vecs.push_back(v);
    end

    // Reset state.
    rst = 1'b1; bus.start = 1'b0; bus.sgn = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy",    64'(bus.busy),    64'd0);
    chk("reset_done",    64'(bus.done),    64'd0);
    chk("reset_hi",      64'(bus.hi),      64'd0);
    chk("reset_lo",      64'(bus.lo),      64'd0);
    chk("reset_alu_sel", 64'(bus.alu_sel), 64'd0);
    chk("reset_alu_op",  64'(bus.alu_op),  64'(ALU_ADD_OP));
    chk("reset_alu_ab",  {bus.alu_a, bus.alu_b}, 64'd0);
    rst = 1'b0;

    // Table-driven vectors.
    foreach (vecs[i]) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, hi, lo, d_after, b_after);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
      chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
      chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
      chk($sformatf("vec%0d_done_pulse", i), 64'(d_after), 64'd0);
      chk($sformatf("vec%0d_idle_after", i), 64'(b_after), 64'd0);
    end

    // Start while busy: second request must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.sgn = 1'b0; bus.a = 32'd3; bus.b = 32'd5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0; n_done = 0;
    for (int k = 1; k <= LAT + 20; k++) begin
      @(negedge clk);
      if (k == 10) begin
        chk("busy_mid_alu_sel", 64'(bus.alu_sel), 64'd1);
        bus.start = 1'b1; bus.a = 32'h0000_0100; bus.b = 32'h0000_0100;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        n_done++;
        if (lat == 0) begin
          lat = k; hi = bus.hi; lo = bus.lo;
        end
      end
    end
    chk("busy_start_latency", 64'(lat), 64'(LAT));
    chk("busy_start_hi", 64'(hi), 64'd0);
    chk("busy_start_lo", 64'(lo), 64'd15);
    chk("busy_start_done_count", 64'(n_done), 64'd1);
    chk("busy_start_idle", 64'(bus.busy), 64'd0);

    // Reset in the middle of the iteration phase.
    @(negedge clk);
    bus.start = 1'b1; bus.sgn = 1'b0; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 1; k <= 12 + ITER_OFS; k++) @(negedge clk);
    chk("midop_busy_before", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midop_rst_busy",    64'(bus.busy),    64'd0);
    chk("midop_rst_done",    64'(bus.done),    64'd0);
    chk("midop_rst_hi",      64'(bus.hi),      64'd0);
    chk("midop_rst_lo",      64'(bus.lo),      64'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("idle_alu_sel_%0d", k), 64'(bus.alu_sel), 64'd0);
    end
    run_op(1'b0, 32'd3, 32'd5, lat, hi, lo, d_after, b_after);
    chk("after_rst_latency", 64'(lat), 64'(LAT));
    chk("after_rst_hi", 64'(hi), 64'd0);
    chk("after_rst_lo", 64'(lo), 64'd15);
    chk("after_rst_alu_sel", 64'(bus.alu_sel), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
